// File: rtl/mc_datapath.sv
// mc_datapath: multi-cycle MIPS-subset core. One instruction at a time walks
// through FETCH/DECODE/EXEC/MEM/WB; the data port stalls in MEM until the
// external memory raises dm_ready.
//
// state  | meaning
// FETCH  | latch instruction word, PC += 4
// DECODE | read rs/rt into A/B, drop unsupported encodings
// EXEC   | ALU op, effective address, or branch/jump PC update
// MEM    | hold data request until dm_ready
// WB     | write ALU result or load data to the register file
module mc_datapath #(
    parameter logic [31:0] PC_INIT = 32'h0000_3000,
    parameter int          DM_AW   = 12
) (
    input  logic             clk,
    input  logic             reset,
    output logic [31:0]      im_addr,
    input  logic [31:0]      im_rdata,
    output logic             dm_req,
    output logic             dm_we,
    output logic [DM_AW-1:0] dm_addr,
    output logic [31:0]      dm_wdata,
    input  logic [31:0]      dm_rdata,
    input  logic             dm_ready,
    output logic [31:0]      pc_out,
    output logic [2:0]       state_out,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    logic [2:0]  state;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [31:0] alu_out;
    logic [31:0] mdr;
    logic [31:0] regs [32];

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic        is_addu, is_subu, is_jr, is_ori, is_lui;
    logic        is_lw, is_sw, is_beq, is_j, is_jal;
    logic        is_rtype_alu;
    logic        supported;

    assign opcode   = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign funct    = ir[5:0];
    assign imm_sext = {{16{ir[15]}}, ir[15:0]};
    assign imm_zext = {16'h0000, ir[15:0]};

    assign is_addu      = (opcode == OP_RTYPE) && (funct == FN_ADDU);
    assign is_subu      = (opcode == OP_RTYPE) && (funct == FN_SUBU);
    assign is_jr        = (opcode == OP_RTYPE) && (funct == FN_JR);
    assign is_ori       = (opcode == OP_ORI);
    assign is_lui       = (opcode == OP_LUI);
    assign is_lw        = (opcode == OP_LW);
    assign is_sw        = (opcode == OP_SW);
    assign is_beq       = (opcode == OP_BEQ);
    assign is_j         = (opcode == OP_J);
    assign is_jal       = (opcode == OP_JAL);
    assign is_rtype_alu = is_addu | is_subu;
    assign supported    = is_rtype_alu | is_jr | is_ori | is_lui | is_lw |
                          is_sw | is_beq | is_j | is_jal;

    assign im_addr   = pc;
    assign pc_out    = pc;
    assign state_out = state;

    // Data port driven purely from registered state so it stays put for the whole MEM stay.
    assign dm_req   = (state == S_MEM);
    assign dm_we    = (state == S_MEM) && is_sw;
    assign dm_addr  = alu_out[DM_AW-1:0];
    assign dm_wdata = b_reg;

    // Register-file write port: jal links in EXEC, everything else writes in WB.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'h0;
        if ((state == S_EXEC) && is_jal) begin
            rf_we    = 1'b1;
            rf_waddr = 5'd31;
            rf_wdata = pc;
        end else if (state == S_WB) begin
            rf_we = 1'b1;
            if (is_rtype_alu) begin
                rf_waddr = rd;
                rf_wdata = alu_out;
            end else if (is_lw) begin
                rf_waddr = rt;
                rf_wdata = mdr;
            end else begin
                rf_waddr = rt;
                rf_wdata = alu_out;
            end
        end
    end

    // Register file storage; $0 is never written so it always reads zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'h0;
            end
        end else if (rf_we && (rf_waddr != 5'd0)) begin
            regs[rf_waddr] <= rf_wdata;
        end
    end

    // Instruction sequencer and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_FETCH;
            pc      <= PC_INIT;
            ir      <= 32'h0;
            a_reg   <= 32'h0;
            b_reg   <= 32'h0;
            alu_out <= 32'h0;
            mdr     <= 32'h0;
        end else begin
            case (state)
                S_FETCH: begin
                    ir    <= im_rdata;
                    pc    <= pc + 32'd4;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    a_reg <= regs[rs];
                    b_reg <= regs[rt];
                    state <= supported ? S_EXEC : S_FETCH;
                end
                S_EXEC: begin
                    state <= S_FETCH;
                    if (is_addu) alu_out <= a_reg + b_reg;
                    if (is_subu) alu_out <= a_reg - b_reg;
                    if (is_ori)  alu_out <= a_reg | imm_zext;
                    if (is_lui)  alu_out <= {ir[15:0], 16'h0000};
                    if (is_lw || is_sw) begin
                        alu_out <= a_reg + imm_sext;
                        state   <= S_MEM;
                    end
                    if (is_rtype_alu || is_ori || is_lui) state <= S_WB;
                    // pc already holds the instruction address + 4 here
                    if (is_beq && (a_reg == b_reg)) pc <= pc + {imm_sext[29:0], 2'b00};
                    if (is_j || is_jal) pc <= {pc[31:28], ir[25:0], 2'b00};
                    if (is_jr) pc <= a_reg;
                end
                S_MEM: begin
                    if (dm_ready) begin
                        if (is_lw) begin
                            mdr   <= dm_rdata;
                            state <= S_WB;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    state <= S_FETCH;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_datapath.sv
// Bench for mc_datapath: an instruction-level reference model runs the program
// first and queues the expected register writes, memory accesses and fetch
// PCs with their cycle costs; a monitor pops and compares as the core runs.
module tb_mc_datapath;

    localparam logic [31:0] PC_INIT = 32'h0000_3000;
    localparam int          DM_AW   = 12;
    localparam int          STEPS   = 100;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [31:0]      im_addr;
    logic [31:0]      im_rdata;
    logic             dm_req;
    logic             dm_we;
    logic [DM_AW-1:0] dm_addr;
    logic [31:0]      dm_wdata;
    logic [31:0]      dm_rdata = 32'h0;
    logic             dm_ready = 1'b0;
    logic [31:0]      pc_out;
    logic [2:0]       state_out;
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [31:0]      rf_wdata;

    always #5 clk = ~clk;

    mc_datapath #(.PC_INIT(PC_INIT), .DM_AW(DM_AW)) dut (
        .clk(clk), .reset(reset),
        .im_addr(im_addr), .im_rdata(im_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .pc_out(pc_out), .state_out(state_out),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    typedef struct packed { logic [4:0] addr; logic [31:0] data; } wr_t;
    typedef struct packed { logic we; logic [11:0] addr; logic [31:0] wdata; } mem_t;
    typedef struct packed { logic [31:0] pc; logic [3:0] cpi; } fetch_t;

    wr_t    exp_wr_q[$];
    mem_t   exp_mem_q[$];
    fetch_t exp_pc_q[$];

    logic [31:0] imem [256];
    logic [31:0] dmem [1024];
    logic [31:0] iss_m [1024];
    logic [31:0] iss_r [32];
    logic [31:0] plan_wd [3];

    int  checks = 0;
    int  failures = 0;
    logic mon_on = 1'b0;
    logic hold_ready = 1'b0;

    logic [31:0] im_off;
    assign im_off   = (im_addr - PC_INIT) >> 2;
    assign im_rdata = (im_off < 32'd256) ? imem[im_off[7:0]] : 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input int word);
        logic [31:0] tgt;
        tgt = PC_INIT + 32'(word * 4);
        return {op, tgt[27:2]};
    endfunction

    task automatic build_program();
        int k, off, rs, rt;
        for (int i = 0; i < 256; i++) imem[i] = 32'h0;
        imem[0]  = enc_i(6'h0D, 0, 1, 16'h1234);   // ori  $1,$0,0x1234
        imem[1]  = enc_i(6'h0F, 0, 2, 16'hABCD);   // lui  $2,0xABCD
        imem[2]  = enc_r(1, 2, 3, 6'h21);          // addu $3,$1,$2
        imem[3]  = enc_i(6'h2B, 0, 3, 16'd4);      // sw   $3,4($0)
        imem[4]  = enc_i(6'h23, 0, 4, 16'd4);      // lw   $4,4($0)
        imem[5]  = enc_i(6'h04, 1, 2, 16'd5);      // beq  $1,$2 (not taken)
        imem[6]  = enc_j(6'h03, 9);                // jal  word 9
        imem[7]  = enc_j(6'h02, 10);               // j    word 10
        imem[8]  = 32'h0;
        imem[9]  = enc_r(31, 0, 0, 6'h08);         // jr   $31
        imem[10] = enc_i(6'h0D, 0, 1, 16'd1);      // ori  $1,$0,1
        imem[11] = enc_r(1, 1, 0, 6'h21);          // addu $0,$1,$1
        imem[12] = enc_r(0, 1, 5, 6'h23);          // subu $5,$0,$1
        imem[13] = 32'hFC00_0000;                  // unsupported opcode 0x3F
        imem[14] = enc_i(6'h04, 1, 1, 16'd1);      // beq  $1,$1,+1 (taken)
        imem[15] = enc_i(6'h0D, 0, 7, 16'hDEAD);   // skipped
        for (int i = 16; i < 76; i++) begin
            k  = $urandom_range(0, 9);
            rs = $urandom_range(0, 7);
            rt = $urandom_range(0, 7);
            case (k)
                0: imem[i] = enc_i(6'h0D, rs, rt, 16'($urandom));
                1: imem[i] = enc_i(6'h0F, rs, rt, 16'($urandom));
                2: imem[i] = enc_r(rs, rt, $urandom_range(0, 7), 6'h21);
                3: imem[i] = enc_r(rs, rt, $urandom_range(0, 7), 6'h23);
                4: imem[i] = enc_i(6'h23, rs, rt, 16'($urandom_range(0, 4095)));
                5: imem[i] = enc_i(6'h2B, rs, rt, 16'($urandom_range(0, 4095)));
                6: begin
                    off = $urandom_range(0, 3);
                    if (i + 1 + off > 76) off = 0;
                    if ($urandom_range(0, 1) == 1) rt = rs;
                    imem[i] = enc_i(6'h04, rs, rt, 16'(off));
                end
                7: imem[i] = 32'h0;
                8: imem[i] = {6'h3F, 26'($urandom)};
                default: begin
                    off = i + 1 + $urandom_range(0, 2);
                    if (off > 76) off = 76;
                    imem[i] = enc_j(6'h02, off);
                end
            endcase
        end
        imem[76] = enc_i(6'h04, 0, 0, 16'hFFFF);    // beq $0,$0,-1 spin
    endtask

    task automatic run_model();
        logic [31:0] pc, ins, npc, a, b, ea, sx, off, wdat;
        logic [4:0]  wadr;
        logic        has_wr;
        logic [3:0]  cpi;
        pc = PC_INIT;
        for (int i = 0; i < 32; i++) iss_r[i] = 32'h0;
        for (int s = 0; s < STEPS; s++) begin
            off  = (pc - PC_INIT) >> 2;
            ins  = (off < 32'd256) ? imem[off[7:0]] : 32'h0;
            a    = iss_r[ins[25:21]];
            b    = iss_r[ins[20:16]];
            sx   = {{16{ins[15]}}, ins[15:0]};
            npc  = pc + 32'd4;
            cpi  = 4'd2;
            has_wr = 1'b0;
            wadr = 5'd0;
            wdat = 32'h0;
            case (ins[31:26])
                6'h00: begin
                    if (ins[5:0] == 6'h21) begin has_wr = 1; wadr = ins[15:11]; wdat = a + b; cpi = 4; end
                    if (ins[5:0] == 6'h23) begin has_wr = 1; wadr = ins[15:11]; wdat = a - b; cpi = 4; end
                    if (ins[5:0] == 6'h08) begin npc = a; cpi = 3; end
                end
                6'h0D: begin has_wr = 1; wadr = ins[20:16]; wdat = a | {16'h0, ins[15:0]}; cpi = 4; end
                6'h0F: begin has_wr = 1; wadr = ins[20:16]; wdat = {ins[15:0], 16'h0}; cpi = 4; end
                6'h23: begin
                    ea = a + sx;
                    exp_mem_q.push_back('{we: 1'b0, addr: ea[11:0], wdata: b});
                    has_wr = 1; wadr = ins[20:16]; wdat = iss_m[ea[11:2]]; cpi = 5;
                end
                6'h2B: begin
                    ea = a + sx;
                    exp_mem_q.push_back('{we: 1'b1, addr: ea[11:0], wdata: b});
                    iss_m[ea[11:2]] = b; cpi = 4;
                end
                6'h04: begin cpi = 3; if (a == b) npc = npc + (sx << 2); end
                6'h02: begin cpi = 3; npc = {npc[31:28], ins[25:0], 2'b00}; end
                6'h03: begin
                    cpi = 3; has_wr = 1; wadr = 5'd31; wdat = npc;
                    npc = {npc[31:28], ins[25:0], 2'b00};
                end
                default: ;
            endcase
            exp_pc_q.push_back('{pc: pc, cpi: cpi});
            if (has_wr) begin
                exp_wr_q.push_back('{addr: wadr, data: wdat});
                if (wadr != 5'd0) iss_r[wadr] = wdat;
            end
            pc = npc;
        end
    endtask

    // Data memory responder: random wait states, random dm_ready noise outside MEM.
    always @(posedge clk) begin
        logic rdy;
        #1;
        rdy = ($urandom_range(0, 2) == 0);
        if (hold_ready) rdy = 1'b0;
        if (dm_req) begin
            dm_rdata = dmem[dm_addr[11:2]];
            dm_ready = rdy;
            if (rdy && dm_we) dmem[dm_addr[11:2]] = dm_wdata;
        end else begin
            dm_ready = 1'($urandom_range(0, 1));
            dm_rdata = $urandom;
        end
    end

    int          cyc = 0;
    int          last_fetch = 0;
    int          stall_cnt = 0;
    int          n_wr = 0;
    logic        have_prev = 1'b0;
    logic [3:0]  prev_cpi = 4'd0;

    // Scoreboard monitor.
    always @(negedge clk) begin
        wr_t    w;
        mem_t   m;
        fetch_t f;
        if (mon_on) begin
            cyc++;
            if (rf_we) begin
                if (exp_wr_q.size() == 0) begin
                    chk("rf_we_unexpected", 32'(rf_we), 32'h0);
                end else begin
                    w = exp_wr_q.pop_front();
                    chk("rf_waddr", 32'(rf_waddr), 32'(w.addr));
                    chk("rf_wdata", rf_wdata, w.data);
                    if (n_wr < 3) chk("plan_wdata", rf_wdata, plan_wd[n_wr]);
                    n_wr++;
                end
            end
            if (dm_req) begin
                if (exp_mem_q.size() == 0) begin
                    chk("dm_req_unexpected", 32'(dm_req), 32'h0);
                end else begin
                    m = exp_mem_q[0];
                    chk("dm_we", 32'(dm_we), 32'(m.we));
                    chk("dm_addr", 32'(dm_addr), 32'(m.addr));
                    chk("dm_wdata", dm_wdata, m.wdata);
                    if (dm_ready) void'(exp_mem_q.pop_front());
                    else stall_cnt++;
                end
            end
            if (state_out == 3'd0) begin
                if (exp_pc_q.size() == 0) begin
                    chk("fetch_unexpected", pc_out, 32'hFFFF_FFFF);
                end else begin
                    f = exp_pc_q.pop_front();
                    chk("fetch_pc", pc_out, f.pc);
                    if (have_prev) chk("instr_cycles", 32'(cyc - last_fetch), 32'(int'(prev_cpi) + stall_cnt));
                    have_prev  = 1'b1;
                    prev_cpi   = f.cpi;
                    stall_cnt  = 0;
                    last_fetch = cyc;
                end
            end
        end
    end

    logic [2:0]  st_log [7];
    logic        we_log [7];
    logic [4:0]  wa_log [7];
    logic [31:0] wd_log [7];
    logic [31:0] pc_log [7];

    initial begin
        int  n;
        logic found;
        plan_wd[0] = 32'h0000_1234;
        plan_wd[1] = 32'hABCD_0000;
        plan_wd[2] = 32'hABCD_1234;
        for (int i = 0; i < 1024; i++) begin
            dmem[i]  = $urandom;
            iss_m[i] = dmem[i];
        end
        build_program();
        run_model();

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state", 32'(state_out), 32'h0);
        chk("rst_pc", pc_out, PC_INIT);
        chk("rst_im_addr", im_addr, PC_INIT);
        chk("rst_dm_req", 32'(dm_req), 32'h0);
        chk("rst_dm_addr", 32'(dm_addr), 32'h0);
        chk("rst_rf_we", 32'(rf_we), 32'h0);
        chk("rst_rf_waddr", 32'(rf_waddr), 32'h0);
        chk("rst_rf_wdata", rf_wdata, 32'h0);

        @(posedge clk);
        #1 reset = 1'b0;
        mon_on = 1'b1;
        n = 0;
        while (exp_pc_q.size() != 0 && n < 30000) begin
            @(negedge clk);
            n++;
        end
        chk("run_budget_left", 32'(exp_pc_q.size()), 32'h0);
        mon_on = 1'b0;
        chk("wr_q_drained", 32'(exp_wr_q.size()), 32'h0);
        chk("mem_q_drained", 32'(exp_mem_q.size()), 32'h0);

        // Reset in the middle of a stalled store.
        reset = 1'b1;
        hold_ready = 1'b1;
        for (int i = 0; i < 256; i++) imem[i] = 32'h0;
        imem[0] = enc_i(6'h0D, 0, 3, 16'h0055);
        imem[1] = enc_i(6'h2B, 0, 3, 16'd8);
        imem[2] = enc_i(6'h04, 0, 0, 16'hFFFF);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        found = 1'b0;
        n = 0;
        while (!found && n < 40) begin
            @(negedge clk);
            found = dm_req;
            n++;
        end
        chk("reach_mem", 32'(found), 32'h1);
        repeat (2) @(negedge clk);
        chk("stall_dm_req", 32'(dm_req), 32'h1);
        chk("stall_dm_addr", 32'(dm_addr), 32'h8);
        chk("stall_dm_wdata", dm_wdata, 32'h55);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_dm_req", 32'(dm_req), 32'h0);
        chk("mrst_state", 32'(state_out), 32'h0);
        chk("mrst_pc", pc_out, PC_INIT);
        imem[0] = enc_r(3, 3, 6, 6'h21);   // addu $6,$3,$3 -> 0 once registers are cleared
        imem[1] = 32'hFC00_0000;
        imem[2] = enc_i(6'h04, 0, 0, 16'hFFFF);
        @(posedge clk);
        #1 reset = 1'b0;
        hold_ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            st_log[k] = state_out;
            we_log[k] = rf_we;
            wa_log[k] = rf_waddr;
            wd_log[k] = rf_wdata;
            pc_log[k] = pc_out;
        end
        chk("post_rst_wb_we", 32'(we_log[3]), 32'h1);
        chk("post_rst_wb_addr", 32'(wa_log[3]), 32'h6);
        chk("post_rst_reg_zero", wd_log[3], 32'h0);
        chk("unsup_fetch_state", 32'(st_log[4]), 32'h0);
        chk("unsup_fetch_pc", pc_log[4], PC_INIT + 32'd4);
        chk("unsup_decode_state", 32'(st_log[5]), 32'h1);
        chk("unsup_no_we", 32'(we_log[4] | we_log[5]), 32'h0);
        chk("unsup_next_state", 32'(st_log[6]), 32'h0);
        chk("unsup_next_pc", pc_log[6], PC_INIT + 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
